request_unit: RTL and testbench
===============================

// Module: request_unit
// PURPOSE
//  Sequences memory requests between the datapath and the cache for the multicycle-memory core.
//  Holds instruction fetch until ihit, then issues/holds a single data read or write until dhit.
//  Generates the PC advance strobe, latches halt, and counts stall cycles for perf debug.
//  Sits directly downstream of datapath decode (fed by ALU result / RF rdat2), upstream of dpif.
// PARAMETERS
//  CNT_W   16   width of stall_cnt (saturating)
// PORTS
//  CLK         in   1     clock, all state on rising edge
//  RST         in   1     asynchronous, active-high reset
//  ihit        in   1     instruction word valid this cycle
//  dhit        in   1     data access complete this cycle
//  mem_read    in   1     decoded instruction is a load
//  mem_write   in   1     decoded instruction is a store
//  halt        in   1     decoded instruction is HALT
//  addr_in     in   32    data address from ALU
//  store_in    in   32    store data from register file
//  imemREN     out  1     instruction read enable
//  dmemREN     out  1     data read enable (registered)
//  dmemWEN     out  1     data write enable (registered)
//  dmemaddr    out  32    held data address (registered)
//  dmemstore   out  32    held store data (registered)
//  pc_en       out  1     1-cycle strobe: instruction retired, advance PC/write RF
//  halt_out    out  1     sticky halt to cache/system
//  stall_cnt   out  CNT_W stall cycles since reset, saturates at all-ones
// BEHAVIOUR
//  Reset (RST=1, async): state=FETCH; dmemREN/WEN/halt_out=0; dmemaddr/dmemstore=0; stall_cnt=0.
//   imemREN and pc_en are forced 0 while RST=1; reset mid-access abandons it without a retire.
//  States: FETCH, MEM, HALT (2-bit encoded).
//  FETCH: imemREN=1.
//   ihit & halt            -> HALT, halt_out<=1, pc_en=0.
//   ihit & (mem_read|mem_write) -> MEM; capture addr_in/store_in; dmemREN<=mem_read;
//     dmemWEN<=mem_write & ~mem_read (read wins if both set); pc_en=0.
//   ihit & no mem op & ~halt -> pc_en=1 (comb, same cycle), stay FETCH.
//   ~ihit                  -> stay, stall_cnt++.
//   halt has priority over mem_read/mem_write.
//  MEM: imemREN=0; dmemREN/WEN, dmemaddr, dmemstore held stable until dhit.
//   dhit  -> pc_en=1 (comb), dmemREN<=0, dmemWEN<=0, -> FETCH. dmemaddr/store keep last value.
//   ~dhit -> stay, stall_cnt++.
//  HALT: imemREN=dmemREN=dmemWEN=pc_en=0, halt_out=1; exits only via RST.
//  ihit outside FETCH and dhit outside MEM are ignored (no state change, no pc_en).
//  Latency: non-memory instr retires in ihit cycle; load/store retires in dhit cycle, min 1 cycle
//   after ihit (MEM entered next edge, dhit sampled there onward).
//  stall_cnt: +1 per stall cycle as above; holds at 2^CNT_W-1; no wrap. Not counted in HALT.
//  pc_en is at most 1 cycle wide per retired instruction; never asserted with dmemREN|dmemWEN
//   rising in the same cycle.
// TESTING
//  1 Reset then ihit=1 every cycle, no mem ops, 4 cycles -> pc_en=1 x4, stall_cnt=0, imemREN=1.
//  2 Load: ihit, mem_read, addr_in=0x100 -> next cycle dmemREN=1, dmemaddr=0x100; dhit after
//    3 waits -> pc_en single pulse in dhit cycle, dmemREN=0 next, stall_cnt=3.
//  3 Store: mem_write, store_in=0xDEADBEEF, addr_in=0x4 -> dmemWEN=1, dmemstore=0xDEADBEEF held
//    while addr_in/store_in toggle; dhit in MEM's 1st cycle -> pc_en 1 cycle, stall_cnt=0.
//  4 mem_read=mem_write=1 -> dmemREN=1, dmemWEN=0; halt=1 with mem_read -> HALT, no dmemREN.
//  5 HALT reached, then ihit/dhit toggled 10 cycles -> halt_out=1, all enables 0, stall_cnt frozen.
//  6 CNT_W=4, ihit held 0 for 20 cycles -> stall_cnt=15; assert RST mid-MEM -> all outputs 0 async.

Source files
------------

// File: rtl/request_unit.sv
// Request sequencer between datapath and cache: holds fetch until ihit, then holds one
// data read/write until dhit, strobes pc_en on retire, latches halt and counts stalls.
module request_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             halt,
    input  logic [31:0]      addr_in,
    input  logic [31:0]      store_in,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic [31:0]      dmemaddr,
    output logic [31:0]      dmemstore,
    output logic             pc_en,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MEM   = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;
    logic   mem_op;
    logic   stall;
    logic   cnt_full;

    assign mem_op   = mem_read | mem_write;
    assign cnt_full = (stall_cnt == {CNT_W{1'b1}});
    assign stall    = ((state == FETCH) & ~ihit) | ((state == MEM) & ~dhit);

    // The two unregistered outputs are gated by RST so they drop the instant reset asserts.
    assign imemREN = ~RST & (state == FETCH);
    assign pc_en   = ~RST & (((state == FETCH) & ihit & ~halt & ~mem_op) |
                             ((state == MEM) & dhit));

    // NOTE: every register here uses non-blocking assignment so all next-state values are
    // computed from the same pre-edge snapshot; blocking would leak updates between lines.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= FETCH;
            dmemREN   <= 1'b0;
            dmemWEN   <= 1'b0;
            dmemaddr  <= 32'd0;
            dmemstore <= 32'd0;
            halt_out  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (stall && !cnt_full)
                stall_cnt <= stall_cnt + CNT_W'(1);

            case (state)
                FETCH: begin
                    if (ihit) begin
                        // halt outranks any memory op decoded alongside it
                        if (halt) begin
                            state    <= HALT;
                            halt_out <= 1'b1;
                        end else if (mem_op) begin
                            state     <= MEM;
                            dmemaddr  <= addr_in;
                            dmemstore <= store_in;
                            dmemREN   <= mem_read;
                            dmemWEN   <= mem_write & ~mem_read;
                        end
                    end
                end
                MEM: begin
                    // address and store data deliberately keep their last value after dhit
                    if (dhit) begin
                        state   <= FETCH;
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: directed vector table, multi-cycle corner sequences
// and randomized traffic compared against a transaction-level reference model.
module tb_request_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0, dhit = 1'b0, mem_read = 1'b0, mem_write = 1'b0, halt = 1'b0;
    logic [31:0] addr_in = '0, store_in = '0;

    logic        imemREN, dmemREN, dmemWEN, pc_en, halt_out;
    logic [31:0] dmemaddr, dmemstore;
    logic [15:0] stall_cnt;

    logic        imemREN4, dmemREN4, dmemWEN4, pc_en4, halt_out4;
    logic [31:0] dmemaddr4, dmemstore4;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    request_unit #(.CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_read(mem_read),
        .mem_write(mem_write), .halt(halt), .addr_in(addr_in), .store_in(store_in),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .pc_en(pc_en), .halt_out(halt_out), .stall_cnt(stall_cnt)
    );

    request_unit #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_read(mem_read),
        .mem_write(mem_write), .halt(halt), .addr_in(addr_in), .store_in(store_in),
        .imemREN(imemREN4), .dmemREN(dmemREN4), .dmemWEN(dmemWEN4), .dmemaddr(dmemaddr4),
        .dmemstore(dmemstore4), .pc_en(pc_en4), .halt_out(halt_out4), .stall_cnt(stall_cnt4)
    );

    // Reference model: an outstanding data transaction (if any), a halted flag and a stall tally.
    bit          m_halted, m_busy, m_rd, m_wr;
    logic [31:0] m_addr, m_store;
    int          m_stalls;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 0; m_busy = 0; m_rd = 0; m_wr = 0;
        m_addr = '0; m_store = '0; m_stalls = 0;
    endtask

    function automatic bit exp_pc_en();
        if (m_halted) return 0;
        if (m_busy) return dhit;
        return ihit && !halt && !mem_read && !mem_write;
    endfunction

    task automatic model_check();
        int sat4, sat16;
        sat16 = (m_stalls > 65535) ? 65535 : m_stalls;
        sat4  = (m_stalls > 15) ? 15 : m_stalls;
        check("m_imemREN",   imemREN,   !m_halted && !m_busy);
        check("m_pc_en",     pc_en,     exp_pc_en());
        check("m_dmemREN",   dmemREN,   m_rd);
        check("m_dmemWEN",   dmemWEN,   m_wr);
        check("m_dmemaddr",  dmemaddr,  m_addr);
        check("m_dmemstore", dmemstore, m_store);
        check("m_halt_out",  halt_out,  m_halted);
        check("m_stall_cnt", stall_cnt, sat16);
        check("m_stall_cnt4", stall_cnt4, sat4);
        check("m_pc_en4",    pc_en4,    exp_pc_en());
    endtask

    task automatic model_update();
        if (m_halted) return;
        if (m_busy) begin
            if (dhit) begin
                m_busy = 0; m_rd = 0; m_wr = 0;
            end else m_stalls++;
        end else if (!ihit) begin
            m_stalls++;
        end else if (halt) begin
            m_halted = 1;
        end else if (mem_read || mem_write) begin
            m_busy = 1; m_rd = mem_read; m_wr = mem_write && !mem_read;
            m_addr = addr_in; m_store = store_in;
        end
    endtask

    task automatic set_in(input logic i, d, r, w, h, input logic [31:0] a, s);
        ihit = i; dhit = d; mem_read = r; mem_write = w; halt = h; addr_in = a; store_in = s;
    endtask

    task automatic sample();
        @(negedge CLK);
        model_check();
    endtask

    task automatic advance();
        model_update();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_imemREN"}, imemREN, 0);
        check({tag, "_pc_en"},   pc_en,   0);
        check({tag, "_dmemREN"}, dmemREN | dmemWEN, 0);
        check({tag, "_addr"},    dmemaddr, 0);
        check({tag, "_store"},   dmemstore, 0);
        check({tag, "_halt"},    halt_out, 0);
        check({tag, "_stall"},   stall_cnt, 0);
        check({tag, "_stall4"},  stall_cnt4, 0);
    endtask

    // Holds RST for one full cycle with hits asserted, checking that nothing leaks out.
    task automatic do_reset();
        RST = 1'b1;
        set_in(1, 1, 0, 0, 0, 32'h0, 32'h0);
        #1;
        check_all_zero("rst");
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic        ihit, dhit, rd, wr, hlt;
        logic [31:0] addr, store;
        logic        e_pc, e_imem, e_dren, e_dwen, e_halt;
        logic [31:0] e_addr, e_store;
        logic [15:0] e_stall;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // reset, 4 plain instructions
        for (int k = 0; k < 4; k++)
            tbl.push_back('{1,0,0,0,0, 32'h0, 32'h0,          1,1,0,0,0, 32'h0, 32'h0, 16'd0});
        // load at 0x100, three dhit waits, then dhit
        tbl.push_back('{1,0,1,0,0, 32'h100, 32'h0,            0,1,0,0,0, 32'h0, 32'h0, 16'd0});
        tbl.push_back('{0,0,0,0,0, 32'h55, 32'h66,            0,0,1,0,0, 32'h100, 32'h0, 16'd0});
        tbl.push_back('{0,0,0,0,0, 32'h55, 32'h66,            0,0,1,0,0, 32'h100, 32'h0, 16'd1});
        tbl.push_back('{0,0,0,0,0, 32'h55, 32'h66,            0,0,1,0,0, 32'h100, 32'h0, 16'd2});
        tbl.push_back('{0,1,0,0,0, 32'h55, 32'h66,            1,0,1,0,0, 32'h100, 32'h0, 16'd3});
        // store 0xDEADBEEF to 0x4, inputs toggled while held, dhit in first MEM cycle
        tbl.push_back('{1,0,0,1,0, 32'h4, 32'hDEADBEEF,       0,1,0,0,0, 32'h100, 32'h0, 16'd3});
        tbl.push_back('{0,1,0,0,0, 32'hFFFFFFFF, 32'h12345678, 1,0,0,1,0, 32'h4, 32'hDEADBEEF, 16'd3});
        // read and write both set: read wins
        tbl.push_back('{1,0,1,1,0, 32'h8, 32'h0,             0,1,0,0,0, 32'h4, 32'hDEADBEEF, 16'd3});
        tbl.push_back('{0,1,0,0,0, 32'h0, 32'h0,             1,0,1,0,0, 32'h8, 32'h0, 16'd3});
        // halt with mem_read: halt wins, no data access
        tbl.push_back('{1,0,1,0,1, 32'h200, 32'h9,           0,1,0,0,0, 32'h8, 32'h0, 16'd3});
        tbl.push_back('{1,1,1,1,0, 32'h0, 32'h0,             0,0,0,0,1, 32'h8, 32'h0, 16'd3});

        model_reset();
        #2;
        do_reset();

        foreach (tbl[i]) begin
            set_in(tbl[i].ihit, tbl[i].dhit, tbl[i].rd, tbl[i].wr, tbl[i].hlt,
                   tbl[i].addr, tbl[i].store);
            sample();
            check($sformatf("v%0d_pc_en", i),   pc_en,     tbl[i].e_pc);
            check($sformatf("v%0d_imemREN", i), imemREN,   tbl[i].e_imem);
            check($sformatf("v%0d_dmemREN", i), dmemREN,   tbl[i].e_dren);
            check($sformatf("v%0d_dmemWEN", i), dmemWEN,   tbl[i].e_dwen);
            check($sformatf("v%0d_halt", i),    halt_out,  tbl[i].e_halt);
            check($sformatf("v%0d_addr", i),    dmemaddr,  tbl[i].e_addr);
            check($sformatf("v%0d_store", i),   dmemstore, tbl[i].e_store);
            check($sformatf("v%0d_stall", i),   stall_cnt, tbl[i].e_stall);
            advance();
        end

        // halted: hits toggle for 10 cycles, everything frozen
        for (int k = 0; k < 10; k++) begin
            set_in(k[0], ~k[0], $urandom_range(0, 1), $urandom_range(0, 1), 0, $urandom, $urandom);
            sample();
            check("halt_hold_out", halt_out, 1);
            check("halt_hold_en", {imemREN, dmemREN, dmemWEN, pc_en}, 4'b0000);
            check("halt_hold_stall", stall_cnt, 16'd3);
            advance();
        end

        // saturation of the narrow counter, then reset in the middle of a data access
        do_reset();
        for (int k = 0; k < 20; k++) begin
            set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
            sample();
            advance();
        end
        check("sat_cnt4", stall_cnt4, 4'd15);
        check("sat_cnt16", stall_cnt, 16'd20);
        set_in(1, 0, 0, 1, 0, 32'h40, 32'hCAFEF00D);
        sample();
        advance();
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
        sample();
        check("mid_mem_wen", dmemWEN, 1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        set_in(1, 1, 1, 0, 0, 32'h80, 32'h1);
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // randomized traffic with periodic resets
        for (int seg = 0; seg < 5; seg++) begin
            do_reset();
            for (int k = 0; k < 150; k++) begin
                set_in(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
                       ($urandom % 4) == 1, ($urandom % 60) == 0, $urandom, $urandom);
                sample();
                advance();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
